// File: rtl/tpu_host_ctrl.sv
// tpu_host_ctrl: launches a job on the TPU, waits for busy to drop, then streams the
// C matrix from the C global buffer to the host through a 2-entry output FIFO.
module tpu_host_ctrl #(
  parameter int ARRAY   = 4,
  parameter int DATA_W  = 128,
  parameter int IDX_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [7:0]        job_K,
  input  logic [7:0]        job_M,
  input  logic [7:0]        job_N,
  output logic              in_valid,
  output logic [7:0]        K,
  output logic [7:0]        M,
  output logic [7:0]        N,
  input  logic              busy,
  output logic [IDX_W-1:0]  C_index,
  input  logic [DATA_W-1:0] C_data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_GUARD  = 3'd2,
    S_WAIT   = 3'd3,
    S_READ   = 3'd4
  } state_t;

  state_t            state_r;
  logic              job_ready_r;
  logic              in_valid_r;
  logic              done_r;
  logic              timeout_err_r;
  logic              res_valid_r;
  logic [7:0]        k_r;
  logic [7:0]        m_r;
  logic [7:0]        n_r;
  logic [15:0]       total_r;
  logic [15:0]       issued_r;
  logic [IDX_W-1:0]  c_index_r;
  logic [31:0]       wait_cnt_r;
  logic              rd_pend_r;
  logic              rd_pend_last_r;
  logic [DATA_W-1:0] fifo_data_r [2];
  logic              fifo_last_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;

  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              issue_last_s;
  logic              job_zero_s;
  logic [2:0]        occ_s;
  logic [1:0]        count_nxt_s;
  logic [15:0]       n_blocks_s;
  logic [15:0]       job_total_s;

  // Read-issue credit, FIFO occupancy and job size decode
  always_comb begin
    pop_s       = res_valid_r & res_ready;
    push_s      = rd_pend_r;
    // A read presented now lands one edge after the in-flight one; crediting this
    // cycle's pop sustains one word per cycle while never exceeding two entries.
    occ_s       = {1'b0, count_r} + {2'b00, rd_pend_r} - {2'b00, pop_s};
    count_nxt_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
    issue_s      = 1'b0;
    issue_last_s = 1'b0;
    if ((state_r == S_READ) && (issued_r != total_r) && (occ_s <= 3'd1)) begin
      issue_s      = 1'b1;
      issue_last_s = (issued_r == (total_r - 16'd1));
    end else begin
      issue_s      = 1'b0;
      issue_last_s = 1'b0;
    end
    n_blocks_s  = (16'(job_N) + 16'(ARRAY - 1)) / 16'(ARRAY);
    job_total_s = 16'(job_M) * n_blocks_s;
    job_zero_s  = (job_K == 8'd0) || (job_M == 8'd0) || (job_N == 8'd0);
  end

  // Job FSM, read pipeline and output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      job_ready_r    <= 1'b0;
      in_valid_r     <= 1'b0;
      done_r         <= 1'b0;
      timeout_err_r  <= 1'b0;
      res_valid_r    <= 1'b0;
      k_r            <= 8'd0;
      m_r            <= 8'd0;
      n_r            <= 8'd0;
      total_r        <= 16'd0;
      issued_r       <= 16'd0;
      c_index_r      <= {IDX_W{1'b0}};
      wait_cnt_r     <= 32'd0;
      rd_pend_r      <= 1'b0;
      rd_pend_last_r <= 1'b0;
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_r[i] <= {DATA_W{1'b0}};
        fifo_last_r[i] <= 1'b0;
      end
    end else begin
      in_valid_r    <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;

      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= C_data_out;
        fifo_last_r[wr_ptr_r] <= rd_pend_last_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r        <= count_nxt_s;
      res_valid_r    <= (count_nxt_s != 2'd0);
      rd_pend_r      <= issue_s;
      rd_pend_last_r <= issue_last_s;

      case (state_r)
        S_IDLE: begin
          job_ready_r <= 1'b1;
          if (job_valid && job_ready_r) begin
            k_r     <= job_K;
            m_r     <= job_M;
            n_r     <= job_N;
            total_r <= job_total_s;
            if (job_zero_s) begin
              done_r <= 1'b1;
            end else begin
              state_r     <= S_LAUNCH;
              in_valid_r  <= 1'b1;
              job_ready_r <= 1'b0;
            end
          end
        end
        S_LAUNCH: begin
          state_r    <= S_GUARD;
          wait_cnt_r <= 32'd0;
        end
        // The TPU only raises busy the cycle after in_valid, so busy is not trusted yet
        S_GUARD: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (!busy) begin
            state_r   <= S_READ;
            c_index_r <= {IDX_W{1'b0}};
            issued_r  <= 16'd0;
          end else if ((TIMEOUT != 32'sd0) && ((wait_cnt_r + 32'd1) == 32'(TIMEOUT))) begin
            timeout_err_r <= 1'b1;
            state_r       <= S_IDLE;
            job_ready_r   <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
        end
        S_READ: begin
          if (issue_s) begin
            issued_r <= issued_r + 16'd1;
            if (!issue_last_s) begin
              c_index_r <= c_index_r + IDX_W'(1);
            end
          end
          if (pop_s && fifo_last_r[rd_ptr_r]) begin
            done_r      <= 1'b1;
            state_r     <= S_IDLE;
            job_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          job_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign job_ready   = job_ready_r;
  assign in_valid    = in_valid_r;
  assign K           = k_r;
  assign M           = m_r;
  assign N           = n_r;
  assign C_index     = c_index_r;
  assign res_valid   = res_valid_r;
  assign res_data    = fifo_data_r[rd_ptr_r];
  assign res_last    = fifo_last_r[rd_ptr_r] & res_valid_r;
  assign done        = done_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// Scoreboard bench for tpu_host_ctrl: TPU busy model, C buffer model and a host sink
// with randomized back-pressure; expected words are queued at job issue.
`timescale 1ns/1ps
module tb_tpu_host_ctrl;
  localparam int DATA_W = 128;
  localparam int IDX_W  = 16;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid;
  logic              job_ready;
  logic [7:0]        job_K, job_M, job_N;
  logic              in_valid;
  logic [7:0]        K, M, N;
  logic              busy;
  logic [IDX_W-1:0]  C_index;
  logic [DATA_W-1:0] C_data_out = '0;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic              done;
  logic              timeout_err;

  tpu_host_ctrl #(.ARRAY(4), .DATA_W(DATA_W), .IDX_W(IDX_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_K(job_K), .job_M(job_M), .job_N(job_N), .in_valid(in_valid),
    .K(K), .M(M), .N(N), .busy(busy), .C_index(C_index), .C_data_out(C_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, launch_cyc = 0, n_inv = 0, n_done = 0, n_to = 0, n_pop = 0;
  int done_cyc = 0, to_cyc = 0, first_valid_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  int job_pop0 = 0, inv_run = 0;
  bit launch_seen = 1'b0, got_first = 1'b0, prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  logic [7:0]        exp_k = 8'd0, exp_m = 8'd0, exp_n = 8'd0;
  logic [31:0]       salt = 32'd0;
  int busy_dly = 1, busy_len = 0, ready_mode = 0;
  bit busy_stuck = 1'b0;

  task automatic check_eq(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [31:0] s, input logic [IDX_W-1:0] idx);
    logic [31:0] i32;
    i32 = {16'h0000, idx};
    return {s, s ^ i32, i32 * 32'd2654435761, i32 + 32'h1234_0000};
  endfunction

  // C buffer: data for the index presented in one cycle appears in the next
  always @(posedge clk) C_data_out <= mem_word(salt, C_index);

  // TPU busy model and host back-pressure, driven just after each rising edge
  initial begin : env
    busy = 1'b0;
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      busy = busy_stuck || (launch_seen && (cyc >= launch_cyc + busy_dly) &&
                            (cyc < launch_cyc + busy_dly + busy_len));
      case (ready_mode)
        0: res_ready = 1'b1;
        1: res_ready = ~res_ready;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word, checks holds and pulses
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        inv_run = 0;
      end else begin
        if (in_valid) begin
          inv_run++;
          check_eq("in_valid_width", inv_run, 1);
          n_inv++;
          launch_cyc = cyc;
          launch_seen = 1'b1;
          got_first = 1'b0;
          check_eq("launch_kmn", {K, M, N}, {exp_k, exp_m, exp_n});
        end else begin
          inv_run = 0;
        end
        if (res_valid && !got_first) begin
          got_first = 1'b1;
          first_valid_cyc = cyc;
        end
        if (prev_stall)
          check_eq("stall_hold", {res_valid, res_last, res_data}, {1'b1, prev_last, prev_data});
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_word", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("res_data", res_data, e.data);
            check_eq("res_last", res_last, e.last);
          end
          check_eq("kmn_held", {K, M, N}, {exp_k, exp_m, exp_n});
          if (n_pop == job_pop0) first_pop_cyc = cyc;
          if (res_last) last_pop_cyc = cyc;
          n_pop++;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (timeout_err) begin n_to++; to_cyc = cyc; end
        prev_stall = res_valid && !res_ready;
        prev_data = res_data;
        prev_last = res_last;
      end
    end
  end

  task automatic accept_job(input int k, m, n, output int acc_cyc);
    job_K = 8'(k); job_M = 8'(m); job_N = 8'(n);
    job_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (job_ready) begin acc_cyc = cyc; break; end
    end
    check_eq("accept_bound", acc_cyc >= 0, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    job_K = 8'($urandom); job_M = 8'($urandom); job_N = 8'($urandom);
  endtask

  task automatic run_job(input int k, m, n, dly, len, input bit stuck, input int mode);
    int total, c_rel, inv0, done0, to0, pop0, acc_cyc;
    bit zero, tmo, finished;
    exp_t e;
    zero = (k == 0) || (m == 0) || (n == 0);
    total = zero ? 0 : m * ((n + 3) / 4);
    c_rel = 2;
    while (!stuck && c_rel < 60 && c_rel >= dly && c_rel < dly + len) c_rel++;
    tmo = !zero && (stuck || c_rel >= TMO + 2);
    @(posedge clk); #1;
    busy_dly = dly; busy_len = len; busy_stuck = stuck; ready_mode = mode;
    salt = $urandom;
    exp_k = 8'(k); exp_m = 8'(m); exp_n = 8'(n);
    inv0 = n_inv; done0 = n_done; to0 = n_to; pop0 = n_pop; job_pop0 = n_pop;
    if (!zero && !tmo)
      for (int i = 0; i < total; i++) begin
        e.data = mem_word(salt, IDX_W'(i));
        e.last = (i == total - 1);
        exp_q.push_back(e);
      end
    accept_job(k, m, n, acc_cyc);
    finished = 1'b0;
    for (int i = 0; i < 600 && !finished; i++) begin
      @(negedge clk); #1;
      finished = (n_done != done0) || (n_to != to0);
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("job_finished", finished, 1);
    if (zero) begin
      check_eq("zero_no_launch", n_inv - inv0, 0);
      check_eq("zero_done_cycle", done_cyc - acc_cyc, 1);
    end else begin
      check_eq("launch_count", n_inv - inv0, 1);
      check_eq("launch_cycle", launch_cyc - acc_cyc, 1);
    end
    if (tmo) begin
      check_eq("timeout_count", n_to - to0, 1);
      check_eq("timeout_cycle", to_cyc - launch_cyc, TMO + 2);
    end else begin
      check_eq("no_timeout", n_to - to0, 0);
    end
    check_eq("done_count", n_done - done0, tmo ? 0 : 1);
    check_eq("word_count", n_pop - pop0, (zero || tmo) ? 0 : total);
    if (!zero && !tmo) begin
      check_eq("first_valid_latency", first_valid_cyc - launch_cyc, c_rel + 3);
      check_eq("done_after_last", done_cyc - last_pop_cyc, 1);
      if (mode == 0) check_eq("throughput", last_pop_cyc - first_pop_cyc, total - 1);
    end
    check_eq("scoreboard_empty", exp_q.size(), 0);
    check_eq("job_ready_idle", job_ready, 1);
    busy_stuck = 1'b0;
  endtask

  task automatic reset_mid_read();
    int acc_cyc, pop0, done0;
    exp_t e;
    @(posedge clk); #1;
    busy_dly = 1; busy_len = 3; busy_stuck = 1'b0; ready_mode = 0;
    salt = $urandom;
    exp_k = 8'd4; exp_m = 8'd4; exp_n = 8'd4;
    pop0 = n_pop; done0 = n_done; job_pop0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      e.data = mem_word(salt, IDX_W'(i));
      e.last = (i == 3);
      exp_q.push_back(e);
    end
    accept_job(4, 4, 4, acc_cyc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (n_pop - pop0 >= 2) break;
    end
    check_eq("abort_reached_word2", n_pop - pop0, 2);
    rst = 1'b1;
    #1;
    check_eq("abort_ctrl_zero", {job_ready, in_valid, res_valid, res_last, done, timeout_err}, 0);
    check_eq("abort_data_zero", {C_index, res_data, K, M, N}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_eq("abort_no_done", n_done - done0, 0);
    check_eq("abort_no_more_words", n_pop - pop0, 2);
  endtask

  initial begin : main
    rst = 1'b1;
    job_valid = 1'b0;
    job_K = 8'd0; job_M = 8'd0; job_N = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctrl_zero", {job_ready, in_valid, res_valid, res_last, done, timeout_err}, 0);
    check_eq("rst_data_zero", {C_index, res_data, K, M, N}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("job_ready_before_edge", job_ready, 0);
    @(negedge clk);
    check_eq("job_ready_after_edge", job_ready, 1);

    run_job(4, 4, 4, 1, 10, 1'b0, 0);
    run_job(8, 3, 6, 1, 5, 1'b0, 1);
    run_job(5, 5, 0, 1, 5, 1'b0, 0);
    run_job(3, 2, 4, 1, 0, 1'b1, 0);
    run_job(2, 2, 8, 2, 4, 1'b0, 0);
    reset_mid_read();
    run_job(4, 4, 4, 1, 6, 1'b0, 0);
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(1, 20), $urandom_range(1, 6), $urandom_range(0, 12),
              $urandom_range(1, 3), $urandom_range(0, 8), 1'b0, $urandom_range(0, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
